// File: rtl/zircon_ps2_mouse_init_ctrl.sv
// PS/2 mouse host-side initialisation sequencer.
// Sends Reset (0xFF), Set Sample Rate (0xF3 + rate) and Enable Data Reporting
// (0xF4) through a byte-level PHY, validates every reply, retries a failing
// command up to MAX_RETRY times, and raises stream_en once the mouse is ready.
module zircon_ps2_mouse_init_ctrl #(
  parameter logic [7:0]  SAMPLE_RATE = 8'd100,
  parameter logic [23:0] ACK_TIMEOUT = 24'd960000,
  parameter logic [23:0] BAT_TIMEOUT = 24'd24000000,
  parameter logic [2:0]  MAX_RETRY   = 3'd3
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  output logic       tx_valid,
  output logic [7:0] tx_byte,
  input  logic       tx_ready,
  input  logic       tx_done,
  input  logic       tx_err,
  input  logic       rx_valid,
  input  logic [7:0] rx_byte,
  output logic       busy,
  output logic       stream_en,
  output logic       init_error,
  output logic [2:0] err_code
);

  localparam logic [7:0] CMD_RESET    = 8'hFF;
  localparam logic [7:0] CMD_SET_RATE = 8'hF3;
  localparam logic [7:0] CMD_ENABLE   = 8'hF4;
  localparam logic [7:0] RSP_ACK      = 8'hFA;
  localparam logic [7:0] RSP_RESEND   = 8'hFE;
  localparam logic [7:0] RSP_ERROR    = 8'hFC;
  localparam logic [7:0] RSP_BAT_OK   = 8'hAA;
  localparam logic [7:0] RSP_ID       = 8'h00;

  localparam logic [2:0] ERR_NONE    = 3'd0;
  localparam logic [2:0] ERR_TIMEOUT = 3'd1;
  localparam logic [2:0] ERR_SELF    = 3'd2;
  localparam logic [2:0] ERR_UNEXP   = 3'd3;
  localparam logic [2:0] ERR_TX      = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE, S_SEND, S_WAIT_TX, S_WAIT_ACK, S_WAIT_BAT, S_WAIT_ID, S_DONE, S_FAIL
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  step_q, step_d;
  logic [2:0]  retry_q, retry_d;
  logic [23:0] cnt_q, cnt_d;
  logic        tx_valid_q, tx_valid_d;
  logic [7:0]  tx_byte_q, tx_byte_d;
  logic        busy_q, busy_d;
  logic        stream_en_q, stream_en_d;
  logic        init_error_q, init_error_d;
  logic [2:0]  err_code_q, err_code_d;

  logic        retry_req;
  logic [2:0]  retry_code;
  logic [23:0] limit;
  logic        expired;

  // Command byte for each sequence step.
  function automatic logic [7:0] cmd_byte(input logic [1:0] step);
    case (step)
      2'd0:    cmd_byte = CMD_RESET;
      2'd1:    cmd_byte = CMD_SET_RATE;
      2'd2:    cmd_byte = SAMPLE_RATE;
      default: cmd_byte = CMD_ENABLE;
    endcase
  endfunction

  // The self-test wait is much longer than a plain ACK/ID wait.
  assign limit   = (state_q == S_WAIT_BAT) ? BAT_TIMEOUT : ACK_TIMEOUT;
  assign expired = (cnt_q == limit - 24'd1);

  // Next-state, counters and registered-output values.
  always_comb begin
    state_d      = state_q;
    step_d       = step_q;
    retry_d      = retry_q;
    cnt_d        = '0;
    tx_valid_d   = 1'b0;
    tx_byte_d    = tx_byte_q;
    busy_d       = busy_q;
    stream_en_d  = stream_en_q;
    init_error_d = init_error_q;
    err_code_d   = err_code_q;
    retry_req    = 1'b0;
    retry_code   = ERR_NONE;

    case (state_q)
      S_SEND: begin
        tx_byte_d = cmd_byte(step_q);
        if (tx_valid_q && tx_ready) begin
          state_d = S_WAIT_TX;
        end else begin
          tx_valid_d = 1'b1;
        end
      end
      S_WAIT_TX: begin
        if (tx_done) begin
          state_d = S_WAIT_ACK;
        end else if (tx_err) begin
          retry_req  = 1'b1;
          retry_code = ERR_TX;
        end
      end
      S_WAIT_ACK: begin
        if (rx_valid) begin
          case (rx_byte)
            RSP_ACK: begin
              if (step_q == 2'd0) begin
                state_d = S_WAIT_BAT;
              end else if (step_q == 2'd3) begin
                state_d = S_DONE;
              end else begin
                step_d  = step_q + 2'd1;
                retry_d = '0;
                state_d = S_SEND;
              end
            end
            RSP_RESEND: begin
              retry_req  = 1'b1;
              retry_code = ERR_NONE;
            end
            RSP_ERROR: begin
              retry_req  = 1'b1;
              retry_code = ERR_SELF;
            end
            default: begin
              retry_req  = 1'b1;
              retry_code = ERR_UNEXP;
            end
          endcase
        end else if (expired) begin
          retry_req  = 1'b1;
          retry_code = ERR_TIMEOUT;
        end else begin
          cnt_d = cnt_q + 24'd1;
        end
      end
      S_WAIT_BAT: begin
        if (rx_valid) begin
          if (rx_byte == RSP_BAT_OK) begin
            state_d = S_WAIT_ID;
          end else begin
            retry_req  = 1'b1;
            retry_code = (rx_byte == RSP_ERROR) ? ERR_SELF : ERR_UNEXP;
          end
        end else if (expired) begin
          retry_req  = 1'b1;
          retry_code = ERR_TIMEOUT;
        end else begin
          cnt_d = cnt_q + 24'd1;
        end
      end
      S_WAIT_ID: begin
        if (rx_valid) begin
          if (rx_byte == RSP_ID) begin
            step_d  = 2'd1;
            retry_d = '0;
            state_d = S_SEND;
          end else begin
            retry_req  = 1'b1;
            retry_code = ERR_UNEXP;
          end
        end else if (expired) begin
          retry_req  = 1'b1;
          retry_code = ERR_TIMEOUT;
        end else begin
          cnt_d = cnt_q + 24'd1;
        end
      end
      default: begin
        // IDLE, DONE and FAIL just hold; received bytes are ignored.
      end
    endcase

    // A failed command is re-sent at the same step until the budget runs out.
    if (retry_req) begin
      if (retry_q < MAX_RETRY) begin
        retry_d = retry_q + 3'd1;
        state_d = S_SEND;
      end else begin
        state_d    = S_FAIL;
        err_code_d = retry_code;
      end
    end

    if (state_d == S_DONE) begin
      stream_en_d = 1'b1;
      busy_d      = 1'b0;
    end
    if (state_d == S_FAIL) begin
      init_error_d = 1'b1;
      busy_d       = 1'b0;
    end

    // start overrides everything, including a byte received in the same cycle.
    if (start) begin
      state_d      = S_SEND;
      step_d       = '0;
      retry_d      = '0;
      cnt_d        = '0;
      tx_valid_d   = 1'b0;
      busy_d       = 1'b1;
      stream_en_d  = 1'b0;
      init_error_d = 1'b0;
      err_code_d   = ERR_NONE;
    end
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      step_q       <= '0;
      retry_q      <= '0;
      cnt_q        <= '0;
      tx_valid_q   <= 1'b0;
      tx_byte_q    <= 8'h00;
      busy_q       <= 1'b0;
      stream_en_q  <= 1'b0;
      init_error_q <= 1'b0;
      err_code_q   <= ERR_NONE;
    end else begin
      state_q      <= state_d;
      step_q       <= step_d;
      retry_q      <= retry_d;
      cnt_q        <= cnt_d;
      tx_valid_q   <= tx_valid_d;
      tx_byte_q    <= tx_byte_d;
      busy_q       <= busy_d;
      stream_en_q  <= stream_en_d;
      init_error_q <= init_error_d;
      err_code_q   <= err_code_d;
    end
  end

  assign tx_valid   = tx_valid_q;
  assign tx_byte    = tx_byte_q;
  assign busy       = busy_q;
  assign stream_en  = stream_en_q;
  assign init_error = init_error_q;
  assign err_code   = err_code_q;

endmodule

// File: tb/tb_zircon_ps2_mouse_init_ctrl.sv
// Bench for zircon_ps2_mouse_init_ctrl: an emulated mouse answers each command
// according to a chosen outcome; a step/retry model predicts bytes and results.
module tb_zircon_ps2_mouse_init_ctrl;

  localparam int ACK_TO     = 40;
  localparam int BAT_TO     = 90;
  localparam int MAXR       = 3;
  localparam int WAIT_LIMIT = 100;

  typedef enum int {
    O_OK = 0, O_TXERR = 1, O_ACK_TO = 2, O_ACK_FE = 3, O_ACK_FC = 4, O_ACK_BAD = 5,
    O_BAT_TO = 6, O_BAT_FC = 7, O_BAT_BAD = 8, O_ID_TO = 9, O_ID_BAD = 10, O_ABORT_BAT = 11
  } outcome_t;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       tx_ready = 1'b0;
  logic       tx_done = 1'b0;
  logic       tx_err = 1'b0;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_byte = 8'h00;
  logic       tx_valid;
  logic [7:0] tx_byte;
  logic       busy, stream_en, init_error;
  logic [2:0] err_code;

  int checks = 0;
  int errors = 0;

  logic [7:0] cmd_tbl [4] = '{8'hFF, 8'hF3, 8'd100, 8'hF4};
  outcome_t   plan_q[$];
  logic [7:0] sent_log[$];
  int         fixed_gap = 0;
  bit         res_done;
  int         res_code;
  logic       mon_en = 1'b0;
  logic       prev_valid = 1'b0;
  logic [7:0] prev_byte = 8'h00;

  zircon_ps2_mouse_init_ctrl #(
    .SAMPLE_RATE(8'd100),
    .ACK_TIMEOUT(24'd40),
    .BAT_TIMEOUT(24'd90),
    .MAX_RETRY(3'd3)
  ) dut (
    .clock(clock), .reset(reset), .start(start),
    .tx_valid(tx_valid), .tx_byte(tx_byte), .tx_ready(tx_ready),
    .tx_done(tx_done), .tx_err(tx_err),
    .rx_valid(rx_valid), .rx_byte(rx_byte),
    .busy(busy), .stream_en(stream_en), .init_error(init_error), .err_code(err_code)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle consistency of the outputs.
  always @(negedge clock) begin
    if (mon_en && !reset) begin
      chk("busy_excl_flags", 32'(busy && (stream_en || init_error)), 32'd0);
      chk("done_excl_fail", 32'(stream_en && init_error), 32'd0);
      chk("valid_implies_busy", 32'(tx_valid && !busy), 32'd0);
      chk("code_implies_fail", 32'((err_code != 3'd0) && !init_error), 32'd0);
      if (prev_valid && tx_valid) chk("tx_byte_stable", 32'(tx_byte), 32'(prev_byte));
    end
    prev_valid <= tx_valid;
    prev_byte  <= tx_byte;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic rx_pulse(input logic [7:0] b);
    rx_byte  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  // Stay quiet for exactly n cycles; the wait must still be pending before the last.
  task automatic silence(input int n);
    repeat (n - 1) tick();
    chk("pre_expiry_state", 32'({busy, init_error, tx_valid}), 32'b100);
    tick();
  endtask

  function automatic logic [7:0] rand_except(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    logic [7:0] v;
    do v = 8'($urandom); while (v == a || v == b || v == c);
    return v;
  endfunction

  function automatic int resp_delay(input int limit);
    if ($urandom_range(0, 3) == 0) return limit - 1;
    return int'($urandom_range(0, limit - 1));
  endfunction

  function automatic int code_of(input outcome_t o);
    case (o)
      O_TXERR:                     return 4;
      O_ACK_TO, O_BAT_TO, O_ID_TO: return 1;
      O_ACK_FE:                    return 0;
      O_ACK_FC, O_BAT_FC:          return 2;
      default:                     return 3;
    endcase
  endfunction

  // Emulated PHY + mouse for one command transmission.
  task automatic do_attempt(input outcome_t o, output logic [7:0] sent, output int n, output bit ok);
    int gap;
    int d;
    ok = 1'b1;
    n = 0;
    sent = 8'h00;
    while (tx_valid !== 1'b1 && n < WAIT_LIMIT) begin
      rx_byte  = 8'($urandom);
      rx_valid = ($urandom_range(0, 3) == 0);
      tick();
      rx_valid = 1'b0;
      n++;
    end
    if (tx_valid !== 1'b1) begin
      chk("tx_request_seen", 32'(tx_valid), 32'd1);
      ok = 1'b0;
      return;
    end
    sent = tx_byte;
    repeat ($urandom_range(0, 2)) begin
      tick();
      chk("tx_valid_held", 32'(tx_valid), 32'd1);
    end
    tx_ready = 1'b1;
    tick();
    tx_ready = 1'b0;
    chk("tx_valid_fall", 32'(tx_valid), 32'd0);
    gap = (fixed_gap > 0) ? fixed_gap : int'($urandom_range(1, 12));
    repeat (gap - 1) begin
      rx_byte  = 8'($urandom);
      rx_valid = ($urandom_range(0, 3) == 0);
      tick();
      rx_valid = 1'b0;
    end
    if (o == O_TXERR) begin
      tx_err = 1'b1;
      tick();
      tx_err = 1'b0;
      return;
    end
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    if (o == O_ACK_TO) begin
      silence(ACK_TO);
      return;
    end
    d = resp_delay(ACK_TO);
    repeat (d) tick();
    case (o)
      O_ACK_FE:  begin rx_pulse(8'hFE); return; end
      O_ACK_FC:  begin rx_pulse(8'hFC); return; end
      O_ACK_BAD: begin rx_pulse(rand_except(8'hFA, 8'hFE, 8'hFC)); return; end
      default:   rx_pulse(8'hFA);
    endcase
    if (sent != 8'hFF) return;
    if (o == O_BAT_TO) begin
      silence(BAT_TO);
      return;
    end
    d = resp_delay(BAT_TO);
    repeat (d) tick();
    if (o == O_ABORT_BAT) begin
      start    = 1'b1;
      rx_byte  = 8'hAA;
      rx_valid = 1'b1;
      tick();
      start    = 1'b0;
      rx_valid = 1'b0;
      return;
    end
    case (o)
      O_BAT_FC:  begin rx_pulse(8'hFC); return; end
      O_BAT_BAD: begin rx_pulse(rand_except(8'hAA, 8'hFC, 8'hAA)); return; end
      default:   rx_pulse(8'hAA);
    endcase
    if (o == O_ID_TO) begin
      silence(ACK_TO);
      return;
    end
    d = resp_delay(ACK_TO);
    repeat (d) tick();
    if (o == O_ID_BAD) rx_pulse(rand_except(8'h00, 8'h00, 8'h00));
    else rx_pulse(8'h00);
  endtask

  // One full init sequence; the model tracks only step and retry count.
  task automatic run_seq(input bit random_mode, input bit do_start);
    int step = 0;
    int retry = 0;
    int n;
    bit fin = 1'b0;
    bit ok;
    bit exp_done = 1'b0;
    int exp_code = 0;
    outcome_t o;
    logic [7:0] b;
    sent_log.delete();
    res_done = 1'b0;
    res_code = -1;
    if (do_start) begin
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("busy_after_start", 32'({busy, tx_valid}), 32'b10);
      chk("flags_cleared", 32'({stream_en, init_error, err_code}), 32'd0);
    end
    while (!fin) begin
      if (random_mode) begin
        if ($urandom_range(0, 99) < 55) o = O_OK;
        else o = outcome_t'($urandom_range(1, (step == 0) ? 10 : 5));
      end else if (plan_q.size() > 0) begin
        o = plan_q.pop_front();
      end else begin
        o = O_OK;
      end
      do_attempt(o, b, n, ok);
      if (!ok) break;
      sent_log.push_back(b);
      chk("send_latency", 32'(n), 32'd1);
      chk("tx_byte_expected", 32'(b), 32'(cmd_tbl[step]));
      if (o == O_OK) begin
        if (step == 3) begin
          fin = 1'b1; exp_done = 1'b1; exp_code = 0;
        end else begin
          step++; retry = 0;
        end
      end else if (retry < MAXR) begin
        retry++;
      end else begin
        fin = 1'b1; exp_done = 1'b0; exp_code = code_of(o);
      end
      if (fin) begin
        chk("stream_en_final", 32'(stream_en), 32'(exp_done));
        chk("init_error_final", 32'(init_error), 32'(!exp_done));
        chk("busy_final", 32'({busy, tx_valid}), 32'd0);
        chk("err_code_final", 32'(err_code), 32'(exp_code));
        res_done = stream_en;
        res_code = int'(err_code);
      end else begin
        chk("busy_mid", 32'({busy, stream_en, init_error}), 32'b100);
      end
    end
    if (fin) begin
      rx_pulse(8'hFA);
      rx_pulse(8'hAA);
      rx_pulse(8'h00);
      tick();
      chk("hold_after_end", 32'({busy, stream_en, init_error, err_code, tx_valid}),
          32'({1'b0, exp_done, !exp_done, 3'(exp_code), 1'b0}));
    end
  endtask

  task automatic plan_add(input outcome_t o, input int times);
    repeat (times) plan_q.push_back(o);
  endtask

  task automatic async_reset_check(input string tag);
    #3;
    reset = 1'b1;
    #1;
    chk({"rst_outputs_", tag}, 32'({tx_valid, tx_byte, busy, stream_en, init_error, err_code}), 32'd0);
    tick();
    tick();
    reset = 1'b0;
    tick();
    chk({"rst_idle_", tag}, 32'({busy, tx_valid, stream_en, init_error}), 32'd0);
  endtask

  initial begin
    #900000;
    errors++;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    logic [7:0] b;
    int n;
    bit ok;

    tick();
    tick();
    chk("reset_state", 32'({tx_valid, tx_byte, busy, stream_en, init_error, err_code}), 32'd0);
    reset = 1'b0;
    tick();
    mon_en = 1'b1;
    chk("idle_after_reset", 32'({busy, tx_valid}), 32'd0);

    // Happy path, tx_done 100 cycles after each handshake.
    plan_q.delete();
    fixed_gap = 100;
    run_seq(1'b0, 1'b1);
    fixed_gap = 0;
    chk("happy_count", 32'(sent_log.size()), 32'd4);
    chk("happy_b0", 32'(sent_log[0]), 32'h FF);
    chk("happy_b1", 32'(sent_log[1]), 32'h F3);
    chk("happy_b2", 32'(sent_log[2]), 32'h 64);
    chk("happy_b3", 32'(sent_log[3]), 32'h F4);
    chk("happy_result", 32'({res_done, 3'(res_code)}), 32'b1000);

    // One Resend on 0xF3.
    plan_q.delete(); plan_add(O_OK, 1); plan_add(O_ACK_FE, 1);
    run_seq(1'b0, 1'b1);
    chk("resend_count", 32'(sent_log.size()), 32'd5);
    chk("resend_b2", 32'(sent_log[2]), 32'h F3);
    chk("resend_b3", 32'(sent_log[3]), 32'h 64);
    chk("resend_done", 32'(res_done), 32'd1);

    // Resend exhaustion on 0xF4.
    plan_q.delete(); plan_add(O_OK, 3); plan_add(O_ACK_FE, 4);
    run_seq(1'b0, 1'b1);
    chk("fe_exhaust_count", 32'(sent_log.size()), 32'd7);
    chk("fe_exhaust_last", 32'(sent_log[6]), 32'h F4);
    chk("fe_exhaust_result", 32'({init_error, err_code}), 32'b1000);

    // Self-test failure after reset ACK.
    plan_q.delete(); plan_add(O_BAT_FC, 4);
    run_seq(1'b0, 1'b1);
    chk("bat_fc_count", 32'(sent_log.size()), 32'd4);
    chk("bat_fc_last", 32'(sent_log[3]), 32'h FF);
    chk("bat_fc_code", 32'(res_code), 32'd2);

    // Silent mouse after tx_done.
    plan_q.delete(); plan_add(O_ACK_TO, 4);
    run_seq(1'b0, 1'b1);
    chk("ack_to_count", 32'(sent_log.size()), 32'd4);
    chk("ack_to_code", 32'(res_code), 32'd1);

    // Unexpected ID byte.
    plan_q.delete(); plan_add(O_ID_BAD, 4);
    run_seq(1'b0, 1'b1);
    chk("id_bad_count", 32'(sent_log.size()), 32'd4);
    chk("id_bad_code", 32'(res_code), 32'd3);

    // Line-level send failures on the sample-rate argument, then reset in FAIL.
    plan_q.delete(); plan_add(O_OK, 2); plan_add(O_TXERR, 4);
    run_seq(1'b0, 1'b1);
    chk("txerr_count", 32'(sent_log.size()), 32'd6);
    chk("txerr_last", 32'(sent_log[5]), 32'h 64);
    chk("txerr_code", 32'(res_code), 32'd4);
    async_reset_check("fail");

    // start during WAIT_BAT (together with 0xAA) after two retries.
    start = 1'b1; tick(); start = 1'b0;
    do_attempt(O_ACK_FE, b, n, ok);
    chk("abort_bat_b0", 32'(b), 32'h FF);
    do_attempt(O_ACK_FE, b, n, ok);
    chk("abort_bat_b1", 32'(b), 32'h FF);
    do_attempt(O_ABORT_BAT, b, n, ok);
    chk("abort_bat_state", 32'({busy, tx_valid, stream_en, init_error}), 32'b1000);
    plan_q.delete(); plan_add(O_ACK_FE, 3);
    run_seq(1'b0, 1'b0);
    chk("abort_bat_count", 32'(sent_log.size()), 32'd7);
    chk("abort_bat_done", 32'(res_done), 32'd1);

    // start while 0xF3 is being offered.
    start = 1'b1; tick(); start = 1'b0;
    do_attempt(O_OK, b, n, ok);
    tick();
    chk("abort_send_offer", 32'({tx_valid, tx_byte}), 32'h1F3);
    start = 1'b1; tick(); start = 1'b0;
    chk("abort_send_drop", 32'({tx_valid, busy}), 32'b01);
    plan_q.delete();
    run_seq(1'b0, 1'b0);
    chk("abort_send_first", 32'(sent_log[0]), 32'h FF);
    chk("abort_send_count", 32'(sent_log.size()), 32'd4);

    // Asynchronous reset while 0xF3 is being offered.
    start = 1'b1; tick(); start = 1'b0;
    do_attempt(O_OK, b, n, ok);
    tick();
    chk("reset_send_offer", 32'({tx_valid, tx_byte}), 32'h1F3);
    async_reset_check("send");

    // Randomised sequences.
    for (int i = 0; i < 30; i++) run_seq(1'b1, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
